fs_selftest_checker: RTL and testbench
======================================

// Module: fs_selftest_checker
// PURPOSE
//  Synthesizable stimulus/response checker for the full-subtractor cells (fs, fs_nand).
//  Consumes the DUT's diff/bout outputs and compares them against a golden model.
//  On start, it drives all 8 {a,b,bin} vectors into the DUT and samples diff/bout.
//  It counts mismatches and reports pass/fail. Used as on-chip BIST and as a reusable bench monitor.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles each vector is held before sampling; legal range >=1
//  ERR_W          4  width of the mismatch counter; saturates at 2**ERR_W-1
// PORTS
//  clk               in   1      system clock, rising edge
//  rst               in   1      synchronous, active-high reset
//  start             in   1      level; accepted only in IDLE or DONE
//  a_o               out  1      minuend bit to DUT (registered)
//  b_o               out  1      subtrahend bit to DUT (registered)
//  bin_o             out  1      borrow-in to DUT (registered)
//  diff_i            in   1      DUT difference output
//  bout_i            in   1      DUT borrow-out output
//  busy              out  1      high in DRIVE/CHECK
//  done              out  1      high while in DONE
//  pass              out  1      done & (err_cnt==0)
//  err_cnt           out  ERR_W  saturating mismatch count
//  first_fail_vec    out  3      {a,b,bin} of first mismatching vector
//  first_fail_valid  out  1      first_fail_vec holds a captured vector
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; internal vec=0, settle counter=0.
//  State IDLE:
//   - start=1 -> DRIVE.
//   - Same edge: vec<=0, err_cnt<=0, first_fail_valid<=0, first_fail_vec<=0.
//  State DRIVE:
//   - {a_o,b_o,bin_o}=vec, with a MSB.
//   - Stays for SETTLE_CYCLES cycles, counted by the settle counter, then -> CHECK.
//  State CHECK (1 cycle):
//   - Stimulus is held unchanged.
//   - diff_i/bout_i are sampled at the closing edge.
//   - Golden diff = a^b^bin.
//   - Golden bout = (~a&b)|(~a&bin)|(b&bin).
//   - Mismatch = either bit differs. X/Z counts as a mismatch: use case-inequality in sim.
//   - On mismatch: err_cnt += 1, saturating.
//   - On mismatch with first_fail_valid==0: capture vec, set first_fail_valid.
//   - vec==7 -> DONE. Otherwise vec<=vec+1 -> DRIVE, and the settle counter restarts.
//  State DONE:
//   - done=1; pass=(err_cnt==0).
//   - Stimulus outputs return to 0.
//   - Results are held until start or rst.
//   - start=1 -> DRIVE with the same clearing as IDLE. done/pass drop on that edge.
//  Timing:
//   - Each vector costs SETTLE_CYCLES+1 cycles.
//   - start accepted at edge T -> done=1 after edge T+8*(SETTLE_CYCLES+1).
//  Boundaries:
//   - start while busy: ignored; no restart, no counter clear.
//   - Saturated err_cnt: holds at max; later mismatches are still not captured as first fail.
//   - rst mid-run: returns to IDLE with all outputs 0 on the next edge; partial results are discarded.
//   - vec never wraps; the check of vec 7 always ends the run.
// TESTING
//  1. Golden fs_nand connected, SETTLE_CYCLES=2, pulse start
//     -> done at start_edge+24, pass=1, err_cnt=0, first_fail_valid=0.
//  2. bout_i tied 0
//     -> err_cnt=4 (vectors 001,010,011,111), first_fail_vec=3'b001, pass=0.
//  3. diff_i driven as inverted golden diff
//     -> err_cnt=8, first_fail_vec=3'b000.
//  4. ERR_W=2, diff inverted
//     -> err_cnt saturates at 3, done still asserted at +24.
//  5. start re-pulsed mid-run (vec=3)
//     -> ignored; run ends at the original time; results unchanged.
//  6. rst asserted during CHECK of vec 5
//     -> next cycle: IDLE, busy=0, done=0, err_cnt=0, a_o/b_o/bin_o=0.
//     -> a fresh start then completes normally.

Source files
------------

// File: rtl/fs_selftest_checker.sv
// Self-test sequencer for full-subtractor cells: walks all 8 {a,b,bin}
// vectors, compares diff/bout to the golden equations, counts mismatches.
module fs_selftest_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    output logic             bin_o,
    input  logic             diff_i,
    input  logic             bout_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       first_fail_vec,
    output logic             first_fail_valid
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [2:0]         vec_q, vec_d;
    logic [2:0]         stim_q, stim_d;
    logic [SW-1:0]      settle_q, settle_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [2:0]         ffvec_q, ffvec_d;
    logic               ffval_q, ffval_d;
    logic               gold_diff, gold_bout, mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            stim_q   <= '0;
            settle_q <= '0;
            err_q    <= '0;
            ffvec_q  <= '0;
            ffval_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            stim_q   <= stim_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            ffvec_q  <= ffvec_d;
            ffval_q  <= ffval_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        settle_d  = settle_q;
        err_d     = err_q;
        ffvec_d   = ffvec_q;
        ffval_d   = ffval_q;
        gold_diff = ^vec_q;
        gold_bout = (~vec_q[2] & vec_q[1]) | (~vec_q[2] & vec_q[0])
                  | (vec_q[1] & vec_q[0]);
        // Case-inequality so an X/Z response from the cell is a failure.
        mismatch  = ({diff_i, bout_i} !== {gold_diff, gold_bout});
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = DRIVE;
                    vec_d    = '0;
                    settle_d = '0;
                    err_d    = '0;
                    ffvec_d  = '0;
                    ffval_d  = 1'b0;
                end
            end
            DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = CHECK;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
                    if (!ffval_q) begin
                        ffvec_d = vec_q;
                        ffval_d = 1'b1;
                    end
                end
                if (vec_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 3'd1;
                    state_d = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase
        stim_d = (state_d == DRIVE || state_d == CHECK) ? vec_d : 3'd0;
    end

    assign {a_o, b_o, bin_o}  = stim_q;
    assign busy               = (state_q == DRIVE) || (state_q == CHECK);
    assign done               = (state_q == DONE);
    assign pass               = done && (err_q == '0);
    assign err_cnt            = err_q;
    assign first_fail_vec     = ffvec_q;
    assign first_fail_valid   = ffval_q;

endmodule

// File: tb/tb_fs_selftest_checker.sv
// Bench for fs_selftest_checker: a response table stands in for the cell
// under test; a second instance with ERR_W=2 shows counter saturation.
module tb_fs_selftest_checker;

    logic clk = 1'b0;
    logic rst, start;
    logic a1, b1, c1, d1, bo1, busy1, done1, pass1, fv1;
    logic [3:0] err1;
    logic [2:0] ff1;
    logic a2, b2, c2, d2, bo2, busy2, done2, pass2, fv2;
    logic [1:0] err2;
    logic [2:0] ff2;
    logic [7:0] resp_d, resp_b;
    logic [2:0] v1, v2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fs_selftest_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .a_o(a1), .b_o(b1), .bin_o(c1),
        .diff_i(d1), .bout_i(bo1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .first_fail_vec(ff1), .first_fail_valid(fv1)
    );

    fs_selftest_checker #(.SETTLE_CYCLES(2), .ERR_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start),
        .a_o(a2), .b_o(b2), .bin_o(c2),
        .diff_i(d2), .bout_i(bo2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .first_fail_vec(ff2), .first_fail_valid(fv2)
    );

    // Emulated cell: its response to vector v is resp_d[v]/resp_b[v].
    assign v1  = {a1, b1, c1};
    assign v2  = {a2, b2, c2};
    assign d1  = resp_d[v1];
    assign bo1 = resp_b[v1];
    assign d2  = resp_d[v2];
    assign bo2 = resp_b[v2];

    typedef struct {
        logic [7:0] rd;
        logic [7:0] rb;
        int         err;
        int         ffv;
        int         val;
        string      nm;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: golden subtraction by integer arithmetic on a-b-bin.
    task automatic model(input logic [7:0] rd, input logic [7:0] rb,
                         output int err, output int ffv, output int val);
        err = 0; ffv = 0; val = 0;
        for (int v = 0; v < 8; v++) begin
            int r;
            int gd;
            int gb;
            r  = ((v >> 2) & 1) - ((v >> 1) & 1) - (v & 1);
            gd = (r + 4) % 2;
            gb = (r < 0) ? 1 : 0;
            if (int'(rd[v]) != gd || int'(rb[v]) != gb) begin
                err++;
                if (val == 0) begin
                    ffv = v;
                    val = 1;
                end
            end
        end
    endtask

    task automatic run(input logic [7:0] rd, input logic [7:0] rb,
                       input int e, input int f, input int fval,
                       input string nm);
        bit seq_ok;
        int e2;
        resp_d = rd;
        resp_b = rb;
        seq_ok = 1'b1;
        e2 = (e > 3) ? 3 : e;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (v1 !== 3'(k / 3) || busy1 !== 1'b1 || done1 !== 1'b0)
                seq_ok = 1'b0;
            if (k == 0 && (err1 !== 4'd0 || fv1 !== 1'b0))
                seq_ok = 1'b0;
        end
        chk({nm, ".seq"}, int'(seq_ok), 1);
        @(posedge clk);
        #1;
        chk({nm, ".done"}, int'(done1), 1);
        chk({nm, ".busy"}, int'(busy1), 0);
        chk({nm, ".pass"}, int'(pass1), (e == 0) ? 1 : 0);
        chk({nm, ".err"}, int'(err1), e);
        chk({nm, ".ffvalid"}, int'(fv1), fval);
        chk({nm, ".ffvec"}, int'(ff1), f);
        chk({nm, ".stim0"}, int'(v1), 0);
        chk({nm, ".done2"}, int'(done2), 1);
        chk({nm, ".err2"}, int'(err2), e2);
        chk({nm, ".ffvec2"}, int'(ff2), f);
    endtask

    vec_t tbl[6];

    initial begin
        int e, f, fv;
        tbl[0] = '{8'h96, 8'h8E, 0, 0, 0, "golden"};
        tbl[1] = '{8'h96, 8'h00, 4, 1, 1, "bout0"};
        tbl[2] = '{8'h69, 8'h8E, 8, 0, 1, "diffinv"};
        tbl[3] = '{8'hB6, 8'h8E, 1, 5, 1, "diff_v5"};
        tbl[4] = '{8'h96, 8'hCE, 1, 6, 1, "bout_v6"};
        tbl[5] = '{8'h69, 8'h71, 8, 0, 1, "allbad"};

        rst = 1'b1; start = 1'b0;
        resp_d = 8'h96; resp_b = 8'h8E;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst.busy", int'(busy1), 0);
        chk("rst.done", int'(done1), 0);
        chk("rst.pass", int'(pass1), 0);
        chk("rst.err", int'(err1), 0);
        chk("rst.stim", int'(v1), 0);
        chk("rst.ffvalid", int'(fv1), 0);

        foreach (tbl[i])
            run(tbl[i].rd, tbl[i].rb, tbl[i].err, tbl[i].ffv,
                tbl[i].val, tbl[i].nm);

        repeat (5) @(posedge clk);
        #1;
        chk("hold.done", int'(done1), 1);
        chk("hold.err", int'(err1), 8);

        // start re-pulsed at vec 3 must not restart or clear the run
        resp_d = 8'h94; resp_b = 8'h8E;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("midstart.notdone", int'(done1), 0);
        @(posedge clk);
        #1;
        chk("midstart.done", int'(done1), 1);
        chk("midstart.err", int'(err1), 1);
        chk("midstart.ffvec", int'(ff1), 1);

        // rst during CHECK of vec 5 (cycle after edge T+17)
        resp_d = 8'h69; resp_b = 8'h8E;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        chk("midrst.errbefore", int'(err1), 5);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst.busy", int'(busy1), 0);
        chk("midrst.done", int'(done1), 0);
        chk("midrst.err", int'(err1), 0);
        chk("midrst.stim", int'(v1), 0);
        chk("midrst.ffvalid", int'(fv1), 0);
        run(8'h96, 8'h8E, 0, 0, 0, "afterrst");

        for (int n = 0; n < 20; n++) begin
            logic [7:0] rd, rb;
            rd = 8'($urandom);
            rb = 8'($urandom);
            if (n % 3 == 0) rd = 8'h96 ^ (8'd1 << $urandom_range(7, 0));
            model(rd, rb, e, f, fv);
            run(rd, rb, e, f, fv, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
